pcileech_ft601_responder: RTL and testbench

Synthesizable device-side model of the FT601 245-synchronous FIFO bus: the chip end that pcileech_com talks to. It presents rxf_n/txe_n flags, sources read data when the FPGA master asserts oe_n/rd_n, and captures words written with wr_n. It backs the bus with two internal buffers that are exposed as valid/ready streams. It is used for on-board self-test and simulation of the FT601 path without a USB host.

---
 rtl/pcileech_ft601_responder_if.sv | 41 ++++
 rtl/pcileech_ft601_responder.sv | 129 ++++++++++++
 tb/tb_pcileech_ft601_responder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pcileech_ft601_responder_if.sv
`default_nettype none
// ==========================================================================
// pcileech_ft601_responder_if : FT601 bus + src/snk stream bundle   (rev 1.0)
// ==========================================================================
interface pcileech_ft601_responder_if;
  logic [31:0] ft601_data_i;
  logic [3:0]  ft601_be_i;
  logic [31:0] ft601_data_o;
  logic [3:0]  ft601_be_o;
  logic        ft601_data_oe;
  logic        ft601_rxf_n;
  logic        ft601_txe_n;
  logic        ft601_rd_n;
  logic        ft601_oe_n;
  logic        ft601_wr_n;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [31:0] snk_data;
  logic [3:0]  snk_be;
  logic        snk_valid;
  logic        snk_ready;
  logic [15:0] err_overrun;
  logic [15:0] err_underrun;

  // The responder is the FT601 chip side of the bus.
  modport slave (
    input  ft601_data_i, ft601_be_i, ft601_rd_n, ft601_oe_n, ft601_wr_n,
           src_data, src_valid, snk_ready,
    output ft601_data_o, ft601_be_o, ft601_data_oe, ft601_rxf_n, ft601_txe_n,
           src_ready, snk_data, snk_be, snk_valid, err_overrun, err_underrun
  );

  modport master (
    output ft601_data_i, ft601_be_i, ft601_rd_n, ft601_oe_n, ft601_wr_n,
           src_data, src_valid, snk_ready,
    input  ft601_data_o, ft601_be_o, ft601_data_oe, ft601_rxf_n, ft601_txe_n,
           src_ready, snk_data, snk_be, snk_valid, err_overrun, err_underrun
  );
endinterface
`default_nettype wire

// File: rtl/pcileech_ft601_responder.sv
`default_nettype none
// ==========================================================================
// pcileech_ft601_responder : FT601 245-sync FIFO device model, RD/WR buffers.
// Option FT601_RESP_LOOPBACK_EN: WR head words are fed back into RD. rev 1.0
// ==========================================================================
module pcileech_ft601_responder #(
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  pcileech_ft601_responder_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   rd_mem_q [DEPTH];
  logic [35:0]   wr_mem_q [DEPTH];
  logic [AW-1:0] rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
  logic [AW-1:0] wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic          rxf_n_q, rxf_n_d, txe_n_q, txe_n_d;
  logic [15:0]   ovr_q, ovr_d, unr_q, unr_d;

  logic        rd_nfull, wr_nempty, loop_mv;
  logic        rd_push, rd_pop, wr_push, wr_pop;
  logic        rd_req, src_ready;
  logic [31:0] rd_wdata;
  logic [35:0] wr_head;

  assign rd_nfull  = (rd_cnt_q != FULL);
  assign wr_nempty = (wr_cnt_q != '0);
  assign wr_head   = wr_mem_q[wr_rptr_q];

`ifdef FT601_RESP_LOOPBACK_EN
  assign loop_mv       = wr_nempty & rd_nfull;
  assign wr_pop        = loop_mv;
  assign bus.snk_valid = 1'b0;
`else
  assign loop_mv       = 1'b0;
  assign wr_pop        = wr_nempty & bus.snk_ready;
  assign bus.snk_valid = wr_nempty;
`endif

  // Loopback owns the RD push slot, so src is stalled while it moves a word.
  assign src_ready = ~rst & rd_nfull & ~loop_mv;
  assign rd_push   = loop_mv | (bus.src_valid & src_ready);
  assign rd_wdata  = loop_mv ? wr_head[31:0] : bus.src_data;
  assign rd_req    = ~bus.ft601_oe_n & ~bus.ft601_rd_n;
  assign rd_pop    = rd_req & ~rxf_n_q;
  assign wr_push   = ~bus.ft601_wr_n & ~txe_n_q;

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    rd_wptr_d = rd_wptr_q;
    rd_rptr_d = rd_rptr_q;
    wr_wptr_d = wr_wptr_q;
    wr_rptr_d = wr_rptr_q;
    ovr_d     = ovr_q;
    unr_d     = unr_q;

    if (rd_push) rd_wptr_d = rd_wptr_q + AW'(1);
    if (rd_pop)  rd_rptr_d = rd_rptr_q + AW'(1);
    if (wr_push) wr_wptr_d = wr_wptr_q + AW'(1);
    if (wr_pop)  wr_rptr_d = wr_rptr_q + AW'(1);

    case ({rd_push, rd_pop})
      2'b10:   rd_cnt_d = rd_cnt_q + CW'(1);
      2'b01:   rd_cnt_d = rd_cnt_q - CW'(1);
      default: rd_cnt_d = rd_cnt_q;
    endcase
    case ({wr_push, wr_pop})
      2'b10:   wr_cnt_d = wr_cnt_q + CW'(1);
      2'b01:   wr_cnt_d = wr_cnt_q - CW'(1);
      default: wr_cnt_d = wr_cnt_q;
    endcase

    if (~bus.ft601_wr_n & txe_n_q & (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;
    if (rd_req & rxf_n_q & (unr_q != 16'hFFFF))          unr_d = unr_q + 16'd1;

    // Flags follow the next-state counts so the master never acts on a stale one.
    rxf_n_d = (rd_cnt_d == '0);
    txe_n_d = (wr_cnt_d == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_wptr_q <= '0;
      rd_rptr_q <= '0;
      wr_wptr_q <= '0;
      wr_rptr_q <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      rxf_n_q   <= 1'b1;
      txe_n_q   <= 1'b1;
      ovr_q     <= '0;
      unr_q     <= '0;
    end else begin
      rd_wptr_q <= rd_wptr_d;
      rd_rptr_q <= rd_rptr_d;
      wr_wptr_q <= wr_wptr_d;
      wr_rptr_q <= wr_rptr_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      rxf_n_q   <= rxf_n_d;
      txe_n_q   <= txe_n_d;
      ovr_q     <= ovr_d;
      unr_q     <= unr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rd_push) rd_mem_q[rd_wptr_q] <= rd_wdata;
    if (!rst && wr_push) wr_mem_q[wr_wptr_q] <= {bus.ft601_be_i, bus.ft601_data_i};
  end

  assign bus.ft601_data_o  = (rd_cnt_q == '0) ? 32'h0 : rd_mem_q[rd_rptr_q];
  assign bus.ft601_be_o    = 4'hF;
  assign bus.ft601_data_oe = ~bus.ft601_oe_n & ~rst;
  assign bus.ft601_rxf_n   = rxf_n_q;
  assign bus.ft601_txe_n   = txe_n_q;
  assign bus.src_ready     = src_ready;
  assign bus.snk_data      = wr_head[31:0];
  assign bus.snk_be        = wr_head[35:32];
  assign bus.err_overrun   = ovr_q;
  assign bus.err_underrun  = unr_q;
endmodule
`default_nettype wire

// File: tb/tb_pcileech_ft601_responder.sv
`default_nettype none
// ==========================================================================
// tb_pcileech_ft601_responder : table vectors + random traffic vs queue model
// ==========================================================================
module tb_pcileech_ft601_responder;
  localparam int DEPTH = 16;
  localparam int NWRAP = 3 * DEPTH;
`ifdef FT601_RESP_LOOPBACK_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pcileech_ft601_responder_if bus();
  pcileech_ft601_responder #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain queues for the two buffers.
  logic [31:0] rdq[$];
  logic [35:0] wrq[$];
  int ov_m = 0, un_m = 0;
  bit fresh = 1'b1, chk_en = 1'b0;
  bit last_spush, last_wpush;

  typedef struct {
    bit          rst;
    bit          rd;
    bit          sv;
    logic [31:0] sd;
    bit          e_rxf;
    bit          e_txe;
    bit          e_srdy;
    logic [31:0] e_do;
    logic [15:0] e_un;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.ft601_oe_n = 1'b1; bus.ft601_rd_n = 1'b1; bus.ft601_wr_n = 1'b1;
    bus.src_valid = 1'b0; bus.snk_ready = 1'b0;
  endtask

  // Check all outputs mid-cycle against the model, advance the model, clock once.
  task automatic step();
    bit txe_m, rd_req, rpop, wpush, mv, spush, kpop, srdy;
    logic [35:0] w;
    #4;
    mv   = LOOP && !rst && wrq.size() != 0 && rdq.size() < DEPTH;
    srdy = !rst && rdq.size() < DEPTH && !mv;
    if (chk_en) begin
      chk("rxf_n", bus.ft601_rxf_n, rdq.size() == 0);
      chk("txe_n", bus.ft601_txe_n, fresh || wrq.size() == DEPTH);
      chk("data_o", bus.ft601_data_o, (rdq.size() != 0) ? rdq[0] : 32'h0);
      chk("data_oe", bus.ft601_data_oe, !bus.ft601_oe_n && !rst);
      chk("be_o", bus.ft601_be_o, 4'hF);
      chk("src_ready", bus.src_ready, srdy);
      chk("snk_valid", bus.snk_valid, !LOOP && wrq.size() != 0);
      if (!LOOP && wrq.size() != 0) chk("snk_word", {bus.snk_be, bus.snk_data}, wrq[0]);
      chk("err_overrun", bus.err_overrun, ov_m);
      chk("err_underrun", bus.err_underrun, un_m);
    end
    if (rst) begin
      rdq.delete(); wrq.delete();
      ov_m = 0; un_m = 0; fresh = 1'b1;
      last_spush = 1'b0; last_wpush = 1'b0;
    end else begin
      txe_m  = fresh || wrq.size() == DEPTH;
      rd_req = !bus.ft601_oe_n && !bus.ft601_rd_n;
      rpop   = rd_req && rdq.size() != 0;
      wpush  = !bus.ft601_wr_n && !txe_m;
      spush  = bus.src_valid && srdy;
      kpop   = !LOOP && bus.snk_ready && wrq.size() != 0;
      if (rd_req && rdq.size() == 0 && un_m < 65535) un_m++;
      if (!bus.ft601_wr_n && txe_m && ov_m < 65535) ov_m++;
      if (rpop) w = {4'h0, rdq.pop_front()};
      if (kpop) w = wrq.pop_front();
      if (mv) begin w = wrq.pop_front(); rdq.push_back(w[31:0]); end
      if (spush) rdq.push_back(bus.src_data);
      if (wpush) wrq.push_back({bus.ft601_be_i, bus.ft601_data_i});
      fresh = 1'b0;
      last_spush = spush; last_wpush = wpush;
    end
    @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ssent, wsent, ov0, un0;
    bit rd_go, done;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        16'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        16'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        16'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        16'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'h11111111, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 32'h11111111, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h33333333, 1'b0, 1'b0, 1'b1, 32'h11111111, 16'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h44444444, 1'b0, 1'b0, 1'b1, 32'h11111111, 16'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h22222222, 16'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h33333333, 16'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h44444444, 16'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        16'd0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        16'd1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        16'd1};

    idle();
    bus.ft601_data_i = '0; bus.ft601_be_i = '0; bus.src_data = '0;

    // Reset, then a 4-word read burst overrunning by one strobe.
    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      bus.ft601_oe_n = !tbl[i].rd; bus.ft601_rd_n = !tbl[i].rd;
      bus.src_valid = tbl[i].sv; bus.src_data = tbl[i].sd;
      step();
      chk("tbl_rxf_n", bus.ft601_rxf_n, tbl[i].e_rxf);
      chk("tbl_txe_n", bus.ft601_txe_n, tbl[i].e_txe);
      chk("tbl_src_ready", bus.src_ready, tbl[i].e_srdy);
      chk("tbl_data_o", bus.ft601_data_o, tbl[i].e_do);
      chk("tbl_err_underrun", bus.err_underrun, tbl[i].e_un);
      chk("tbl_err_overrun", bus.err_overrun, 16'd0);
    end
    idle();

`ifdef FT601_RESP_LOOPBACK_EN
    bus.ft601_wr_n = 1'b0; bus.ft601_data_i = 32'hDEADBEEF; bus.ft601_be_i = 4'h3;
    step();
    idle();
    chk("lb_rxf_1cyc", bus.ft601_rxf_n, 1'b1);
    chk("lb_snk_valid", bus.snk_valid, 1'b0);
    step();
    chk("lb_rxf_2cyc", bus.ft601_rxf_n, 1'b0);
    chk("lb_data", bus.ft601_data_o, 32'hDEADBEEF);
    chk("lb_snk_valid2", bus.snk_valid, 1'b0);
    bus.ft601_oe_n = 1'b0; bus.ft601_rd_n = 1'b0;
    step();
    idle();
    chk("lb_rxf_drained", bus.ft601_rxf_n, 1'b1);
`else
    // Fill WR past capacity with the consumer stalled.
    for (int i = 0; i < DEPTH + 2; i++) begin
      bus.ft601_wr_n = 1'b0;
      bus.ft601_data_i = 32'hA0000000 + i;
      bus.ft601_be_i = 4'(i) ^ 4'hA;
      step();
      if (i == DEPTH - 2) chk("fill_txe_open", bus.ft601_txe_n, 1'b0);
      if (i == DEPTH - 1) chk("fill_txe_full", bus.ft601_txe_n, 1'b1);
    end
    idle();
    step();
    chk("fill_overrun", bus.err_overrun, 16'd2);
    chk("fill_snk_valid", bus.snk_valid, 1'b1);
    chk("fill_snk_data", bus.snk_data, 32'hA0000000);
    chk("fill_snk_be", bus.snk_be, 4'hA);
    bus.snk_ready = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) step();
    // One word left: simultaneous write and consume.
    bus.ft601_wr_n = 1'b0; bus.ft601_data_i = 32'h55AA55AA; bus.ft601_be_i = 4'h3;
    step();
    idle();
    chk("simul_snk_valid", bus.snk_valid, 1'b1);
    chk("simul_txe_n", bus.ft601_txe_n, 1'b0);
    chk("simul_snk_word", {bus.snk_be, bus.snk_data}, {4'h3, 32'h55AA55AA});
    bus.snk_ready = 1'b1;
    step();
    idle();
    chk("simul_drained", bus.snk_valid, 1'b0);
`endif

    // Random streaming through both buffers with stalls; master obeys the flags.
    ssent = 0; wsent = 0; ov0 = ov_m; un0 = un_m; done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      bus.src_valid = (ssent < NWRAP) && ($urandom_range(0, 3) != 0);
      bus.src_data = $urandom;
      rd_go = (rdq.size() != 0) && ($urandom_range(0, 2) != 0);
      bus.ft601_oe_n = !rd_go; bus.ft601_rd_n = !rd_go;
      bus.ft601_wr_n = !((wsent < NWRAP) && !(fresh || wrq.size() == DEPTH)
                         && ($urandom_range(0, 2) != 0));
      bus.ft601_data_i = $urandom; bus.ft601_be_i = 4'($urandom);
      bus.snk_ready = 1'($urandom_range(0, 1));
      step();
      if (last_spush) ssent++;
      if (last_wpush) wsent++;
      done = (ssent == NWRAP) && (wsent == NWRAP) && rdq.size() == 0 && wrq.size() == 0;
    end
    idle();
    chk("wrap_done", done, 1'b1);
    step();
    chk("wrap_overrun", bus.err_overrun, ov0);
    chk("wrap_underrun", bus.err_underrun, un0);
    chk("wrap_rxf_n", bus.ft601_rxf_n, 1'b1);

    // Reset in the middle of traffic flushes everything on the same edge.
    bus.src_valid = 1'b1; bus.src_data = 32'h77777777;
    bus.ft601_wr_n = 1'b0; bus.ft601_data_i = 32'h88888888; bus.ft601_be_i = 4'hC;
    step();
    step();
    bus.src_valid = 1'b0;
    bus.ft601_oe_n = 1'b0; bus.ft601_rd_n = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_rxf_n", bus.ft601_rxf_n, 1'b1);
    chk("rst_txe_n", bus.ft601_txe_n, 1'b1);
    chk("rst_snk_valid", bus.snk_valid, 1'b0);
    chk("rst_src_ready", bus.src_ready, 1'b0);
    chk("rst_data_oe", bus.ft601_data_oe, 1'b0);
    chk("rst_err_overrun", bus.err_overrun, 16'd0);
    chk("rst_err_underrun", bus.err_underrun, 16'd0);
    rst = 1'b0;
    idle();
    step();
    chk("rel_txe_n", bus.ft601_txe_n, 1'b0);
    chk("rel_src_ready", bus.src_ready, 1'b1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
